// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encodings used by both the
//               transmitter and receiver, counter width, and the clocks-per-bit
//               computation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

    // Bit-period counter width; supports CYCLE values up to 65536
    localparam int unsigned UART_CNT_W = 16;

    // Line-state encodings shared between transmitter and receiver
    typedef enum logic [2:0] {
        UART_IDLE      = 3'd0,
        UART_START     = 3'd1,
        UART_SEND_BYTE = 3'd2,
        UART_PARITY    = 3'd3,
        UART_STOP      = 3'd4
    } uart_state_t;

    // Clocks per bit: CLK_FRE (MHz) * 1e6 / BAUD_RATE, truncated
    function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                               input int unsigned baud_rate);
        longint unsigned hz;
        hz = 64'(clk_fre) * 64'd1000000;
        return 32'(hz / 64'(baud_rate));
    endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
// ============================================================================
// Module      : uart_baud_cnt
// Description : 16-bit bit-period counter. Counts 0..CYCLE-1 and wraps,
//               pulsing tick on the last count; clr holds it at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CYCLE = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [UART_CNT_W-1:0] LAST_CNT = UART_CNT_W'(CYCLE - 1);

    logic [UART_CNT_W-1:0] cycle_cnt_q;
    logic [UART_CNT_W-1:0] cycle_cnt_d;

    assign tick = (cycle_cnt_q == LAST_CNT);

    // Next count: clear on request or at the end of the bit period
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (clr || tick) begin
            cycle_cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

endmodule : uart_baud_cnt

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter. Accepts a byte over valid/ready and sends
//               start, 8 data bits LSB first, optional even parity, and one
//               stop bit. Define UART_TX_PARITY_EN for 8E1 framing; left
//               undefined the transmitter produces 8N1 frames.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FRE   = 50,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
);

    localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);

    uart_state_t state_q, state_d;
    logic [7:0]  tx_reg_q, tx_reg_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_pin_q, tx_pin_d;
    logic        tx_data_ready_q, tx_data_ready_d;

    logic        accept;
    logic        cnt_clr;
    logic        tick;

    // Idle keeps the counter at zero so the start bit begins with a full period
    assign cnt_clr = (state_q == UART_IDLE);
    assign accept  = tx_data_valid && tx_data_ready_q;

    uart_baud_cnt #(
        .CYCLE (CYCLE)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .tick (tick)
    );

    // Next-state logic; pin and ready are derived from the next state so both
    // leave registers with no path from the inputs
    always_comb begin
        state_d   = state_q;
        tx_reg_d  = tx_reg_q;
        bit_cnt_d = bit_cnt_q;

        case (state_q)
            UART_IDLE: begin
                if (accept) begin
                    tx_reg_d = tx_data;
                    state_d  = UART_START;
                end
            end
            UART_START: begin
                if (tick) begin
                    state_d = UART_SEND_BYTE;
                end
            end
            UART_SEND_BYTE: begin
                if (tick) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = UART_PARITY;
`else
                        state_d   = UART_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_PARITY: begin
                if (tick) begin
                    state_d = UART_STOP;
                end
            end
`endif
            UART_STOP: begin
                if (tick) begin
                    state_d = UART_IDLE;
                end
            end
            default: begin
                state_d = UART_IDLE;
            end
        endcase

        tx_data_ready_d = (state_d == UART_IDLE);

        case (state_d)
            UART_START:     tx_pin_d = 1'b0;
            UART_SEND_BYTE: tx_pin_d = tx_reg_d[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
            UART_PARITY:    tx_pin_d = ^tx_reg_d;
`endif
            default:        tx_pin_d = 1'b1;
        endcase
    end

    // State, shift data and output registers; reset forces the line high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= UART_IDLE;
            tx_reg_q        <= 8'd0;
            bit_cnt_q       <= 3'd0;
            tx_pin_q        <= 1'b1;
            tx_data_ready_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            tx_reg_q        <= tx_reg_d;
            bit_cnt_q       <= bit_cnt_d;
            tx_pin_q        <= tx_pin_d;
            tx_data_ready_q <= tx_data_ready_d;
        end
    end

    assign tx_pin        = tx_pin_q;
    assign tx_data_ready = tx_data_ready_q;

endmodule : uart_tx

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Bytes are queued as they are
//               offered; a line monitor decodes every frame and compares it
//               bit by bit and clock by clock. A second instance at the
//               default parameters checks the 434-clock bit width.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       tx_pin;

    logic [7:0] def_data;
    logic       def_valid;
    logic       def_ready;
    logic       def_pin;

    uart_tx #(
        .CLK_FRE   (1),
        .BAUD_RATE (250000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx_pin        (tx_pin)
    );

    uart_tx dut_def (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (def_data),
        .tx_data_valid (def_valid),
        .tx_data_ready (def_ready),
        .tx_pin        (def_pin)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         in_frame = 1'b0;
    int         prev_start = 0;
    int         last_start = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (NBITS == 11 && i == 9) return ^b;
        return 1'b1;
    endfunction

    // Offer a byte (called at a falling edge); returns at the falling edge after acceptance
    task automatic drive(input logic [7:0] b, input bit keep);
        int n;
        tx_data       = b;
        tx_data_valid = 1'b1;
        exp_q.push_back(b);
        n = 0;
        while (tx_data_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 2000), 32'd1);
        @(negedge clk);
        if (!keep) tx_data_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
    endtask

    // Line monitor: decodes frames starting on a low line, compares every clock
    initial begin : monitor
        logic [7:0] cur;
        bit         aborted;
        bit         first;
        forever begin
            @(negedge clk);
            if (!rst && tx_pin == 1'b0) begin
                in_frame   = 1'b1;
                prev_start = last_start;
                last_start = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    cur = 8'h00;
                end else begin
                    cur = exp_q.pop_front();
                end
                aborted = 1'b0;
                first   = 1'b1;
                for (int i = 0; i < NBITS && !aborted; i++) begin
                    for (int k = 0; k < C && !aborted; k++) begin
                        if (!first) @(negedge clk);
                        first = 1'b0;
                        if (rst) begin
                            aborted = 1'b1;
                        end else begin
                            check($sformatf("byte%02h_bit%0d", cur, i), 32'(tx_pin), 32'(frame_bit(cur, i)));
                            check("busy_ready", 32'(tx_data_ready), 32'd0);
                        end
                    end
                end
                if (!aborted) begin
                    @(negedge clk);
                    if (!rst) begin
                        check("end_ready", 32'(tx_data_ready), 32'd1);
                        check("end_pin", 32'(tx_pin), 32'd1);
                    end
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int lo;
        int hi;
        int n;

        // Reset held with valid asserted
        rst           = 1'b1;
        tx_data       = 8'h55;
        tx_data_valid = 1'b1;
        def_data      = 8'h00;
        def_valid     = 1'b0;
        exp_q.push_back(8'h55);
        repeat (5) begin
            @(negedge clk);
            check("rst_pin", 32'(tx_pin), 32'd1);
            check("rst_ready", 32'(tx_data_ready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(tx_data_ready), 32'd1);
        check("def_ready_after_rst", 32'(def_ready), 32'd1);
        check("idle_pin", 32'(tx_pin), 32'd1);
        @(negedge clk);
        tx_data_valid = 1'b0;
        wait_drain();

        // Back-to-back with valid held; start bits NBITS*C+1 apart
        drive(8'hA5, 1'b1);
        drive(8'h3C, 1'b0);
        wait_drain();
        check("b2b_spacing", 32'(last_start - prev_start), 32'(NBITS * C + 1));

        // Busy: offers and data changes during a frame are ignored
        drive(8'h0F, 1'b0);
        repeat (8) @(negedge clk);
        tx_data       = 8'h33;
        tx_data_valid = 1'b1;
        @(negedge clk);
        tx_data_valid = 1'b0;
        tx_data       = 8'h99;
        repeat (4) @(negedge clk);
        tx_data       = 8'hEE;
        drive(8'hFF, 1'b0);
        wait_drain();

        // Reset at clock 13 of a frame
        drive(8'h5A, 1'b0);
        repeat (12) @(negedge clk);
        check("pre_rst_pin", 32'(tx_pin), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_pin", 32'(tx_pin), 32'd1);
        check("rst_async_ready", 32'(tx_data_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", 32'(tx_data_ready), 32'd1);
        check("pin_after_midrst", 32'(tx_pin), 32'd1);
        drive(8'hC3, 1'b0);
        wait_drain();

        // Parity-relevant bytes (odd and even number of ones)
        drive(8'h07, 1'b0);
        wait_drain();
        drive(8'h03, 1'b0);
        wait_drain();

        // Default-parameter instance: bit width of 434 clocks
        @(negedge clk);
        def_data  = 8'h01;
        def_valid = 1'b1;
        n = 0;
        while (def_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        def_valid = 1'b0;
        lo = 0;
        while (def_pin == 1'b0 && lo < 1000) begin
            lo++;
            @(negedge clk);
        end
        check("def_start_width", 32'(lo), 32'd434);
        hi = 0;
        while (def_pin == 1'b1 && hi < 1000) begin
            hi++;
            @(negedge clk);
        end
        check("def_bit0_width", 32'(hi), 32'd434);
        n = 0;
        while (def_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("def_frame_done", 32'(def_ready), 32'd1);
        check("def_idle_pin", 32'(def_pin), 32'd1);

        wait_drain();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_tx

`default_nettype wire
